// File: rtl/ival_packer.sv
// ival_packer: packs an MSB-first 8-bit valid/ready byte stream into 32-bit
// words held in a one-entry output register with a valid/ready handshake.
// Optional feature macro: IVAL_PARITY_EN adds odd parity checking per byte
// (din_par in, par_err out); words containing a parity failure are dropped.
module ival_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [7:0]       din,
    input  logic             din_sof,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [31:0]      ival,
    output logic             ival_valid,
    input  logic             ival_ready,
    output logic             sync_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] sync_cnt
`ifdef IVAL_PARITY_EN
    ,
    input  logic             din_par,
    output logic             par_err
`endif
);

    localparam int unsigned IDX_W = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

    logic [IDX_W-1:0] idx;
    logic [23:0]      acc;

    logic accept;
    logic resync;
    logic complete;
    logic load;
    logic consume;

`ifdef IVAL_PARITY_EN
    logic bad;
    logic byte_bad;
`endif

    // Byte stall only when completing a word would overwrite an undelivered one
    assign din_ready = (idx != IDX_LAST) || !ival_valid || ival_ready;

    // Handshake decode; a sof byte mid-word restarts the word instead of completing it
    always_comb begin
        accept   = din_valid && din_ready;
        resync   = accept && din_sof && (idx != IDX_W'(0));
        complete = accept && !resync && (idx == IDX_LAST);
        consume  = ival_valid && ival_ready;
`ifdef IVAL_PARITY_EN
        byte_bad = ~^{din_par, din};
        load     = complete && !(bad || byte_bad);
`else
        load     = complete;
`endif
    end

    // Assembly state: byte index and partial-word accumulator
    always_ff @(posedge sysclk) begin
        if (reset) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            if (resync || (idx == IDX_W'(0))) begin
                acc <= {16'h0, din};
                idx <= IDX_W'(1);
            end else if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                acc <= {acc[15:0], din};
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Output register: a new load wins over a concurrent consume
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ival       <= 32'h0;
            ival_valid <= 1'b0;
        end else if (load) begin
            ival       <= {acc, din};
            ival_valid <= 1'b1;
        end else if (consume) begin
            ival_valid <= 1'b0;
        end
    end

    // Delivered-word counter (wrapping) and sync-error tracking (saturating)
    always_ff @(posedge sysclk) begin
        if (reset) begin
            word_cnt <= '0;
            sync_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= resync;
            if (consume) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (resync && (sync_cnt != {CNT_W{1'b1}})) begin
                sync_cnt <= sync_cnt + CNT_W'(1);
            end
        end
    end

`ifdef IVAL_PARITY_EN
    // Per-word parity mark; cleared at word start or resync, reported at completion
    always_ff @(posedge sysclk) begin
        if (reset) begin
            bad     <= 1'b0;
            par_err <= 1'b0;
        end else begin
            par_err <= complete && (bad || byte_bad);
            if (accept) begin
                if (complete) begin
                    bad <= 1'b0;
                end else if (resync || (idx == IDX_W'(0))) begin
                    bad <= byte_bad;
                end else begin
                    bad <= bad || byte_bad;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ival_packer.sv
// Directed self-checking bench for ival_packer (counters built 4 bits wide so
// wrap and saturation are reachable quickly). Define IVAL_PARITY_EN to also
// exercise the parity-drop path.
module tb_ival_packer;

    localparam int unsigned CNT_W = 4;

    logic             sysclk = 1'b0;
    logic             reset;
    logic [7:0]       din;
    logic             din_sof;
    logic             din_valid;
    logic             din_ready;
    logic [31:0]      ival;
    logic             ival_valid;
    logic             ival_ready;
    logic             sync_err;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] sync_cnt;
`ifdef IVAL_PARITY_EN
    logic             din_par;
    logic             par_err;
`endif
    logic             par_flip;

    int errors = 0;
    int checks = 0;

    ival_packer #(.CNT_W(CNT_W)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .din        (din),
        .din_sof    (din_sof),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ival       (ival),
        .ival_valid (ival_valid),
        .ival_ready (ival_ready),
        .sync_err   (sync_err),
        .word_cnt   (word_cnt),
        .sync_cnt   (sync_cnt)
`ifdef IVAL_PARITY_EN
        ,
        .din_par    (din_par),
        .par_err    (par_err)
`endif
    );

    always #5 sysclk = ~sysclk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle (caller guarantees din_ready)
    task automatic put(input logic [7:0] b, input logic sof);
        din       = b;
        din_sof   = sof;
        din_valid = 1'b1;
`ifdef IVAL_PARITY_EN
        din_par   = (~^b) ^ par_flip;
`endif
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        par_flip  = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        din        = 8'h0;
        din_sof    = 1'b0;
        din_valid  = 1'b0;
        ival_ready = 1'b0;
        par_flip   = 1'b0;
`ifdef IVAL_PARITY_EN
        din_par    = 1'b0;
`endif
        @(negedge sysclk);
        do_reset();

        // Reset state
        check("rst_ival", ival, 32'h0);
        check("rst_valid", 32'(ival_valid), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_sync_cnt", 32'(sync_cnt), 32'd0);

        // Basic word, consumer ready
        ival_ready = 1'b1;
        put(8'h12, 1'b1);
        put(8'h34, 1'b0);
        put(8'h56, 1'b0);
        check("w1_not_yet", 32'(ival_valid), 32'd0);
        put(8'h78, 1'b0);
        check("w1_ival", ival, 32'h12345678);
        check("w1_valid", 32'(ival_valid), 32'd1);
        tick();
        check("w1_valid_drop", 32'(ival_valid), 32'd0);
        check("w1_ival_hold", ival, 32'h12345678);
        check("w1_cnt", 32'(word_cnt), 32'd1);

        // Backpressure: second word stalls on its last byte
        ival_ready = 1'b0;
        for (int i = 1; i <= 7; i++) put(8'(i), i == 1);
        check("bp_hold_ival", ival, 32'h01020304);
        check("bp_hold_valid", 32'(ival_valid), 32'd1);
        din       = 8'h08;
        din_valid = 1'b1;
`ifdef IVAL_PARITY_EN
        din_par   = ~^din;
`endif
        #1;
        check("bp_din_ready_low", 32'(din_ready), 32'd0);
        tick();
        check("bp_still_stalled", ival, 32'h01020304);
        ival_ready = 1'b1;
        #1;
        check("bp_din_ready_high", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        check("bp_w2_ival", ival, 32'h05060708);
        check("bp_w2_valid", 32'(ival_valid), 32'd1);
        check("bp_cnt2", 32'(word_cnt), 32'd2);
        tick();
        check("bp_w2_drop", 32'(ival_valid), 32'd0);
        check("bp_cnt3", 32'(word_cnt), 32'd3);

        // Resync mid-word
        put(8'hAA, 1'b1);
        put(8'hBB, 1'b0);
        check("sync_pre", 32'(sync_err), 32'd0);
        put(8'h11, 1'b1);
        check("sync_pulse", 32'(sync_err), 32'd1);
        check("sync_cnt1", 32'(sync_cnt), 32'd1);
        put(8'h22, 1'b0);
        check("sync_pulse_end", 32'(sync_err), 32'd0);
        put(8'h33, 1'b0);
        put(8'h44, 1'b0);
        check("sync_ival", ival, 32'h11223344);
        check("sync_valid", 32'(ival_valid), 32'd1);
        tick();
        check("sync_wcnt", 32'(word_cnt), 32'd4);

        // Reset mid-word, then a fresh word without sof
        put(8'hDE, 1'b1);
        put(8'hAD, 1'b0);
        do_reset();
        check("mid_rst_wcnt", 32'(word_cnt), 32'd0);
        check("mid_rst_scnt", 32'(sync_cnt), 32'd0);
        check("mid_rst_ival", ival, 32'h0);
        put(8'hCA, 1'b0);
        put(8'hFE, 1'b0);
        put(8'hBA, 1'b0);
        put(8'hBE, 1'b0);
        check("fresh_ival", ival, 32'hCAFEBABE);
        check("fresh_wcnt_pre", 32'(word_cnt), 32'd0);
        check("fresh_no_sync", 32'(sync_cnt), 32'd0);
        tick();
        check("fresh_wcnt", 32'(word_cnt), 32'd1);

`ifdef IVAL_PARITY_EN
        // Bad parity on byte 2 drops the word; next word is clean
        put(8'h12, 1'b1);
        put(8'h34, 1'b0);
        par_flip = 1'b1;
        put(8'h56, 1'b0);
        put(8'h78, 1'b0);
        check("par_no_valid", 32'(ival_valid), 32'd0);
        check("par_err_pulse", 32'(par_err), 32'd1);
        check("par_ival_kept", ival, 32'hCAFEBABE);
        put(8'h9A, 1'b1);
        check("par_err_end", 32'(par_err), 32'd0);
        put(8'hBC, 1'b0);
        put(8'hDE, 1'b0);
        put(8'hF0, 1'b0);
        check("par_good_ival", ival, 32'h9ABCDEF0);
        check("par_good_valid", 32'(ival_valid), 32'd1);
        tick();
`endif

        // Counter wrap: 2^CNT_W + 1 words back to back
        do_reset();
        ival_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            put(8'(i), 1'b1);
            put(8'hA5, 1'b0);
            put(8'h5A, 1'b0);
            put(~8'(i), 1'b0);
        end
        check("wrap_last_ival", ival, 32'h10A55AEF);
        tick();
        check("wrap_wcnt", 32'(word_cnt), 32'd1);

        // Sync counter saturation: 16 resyncs into a 4-bit counter
        put(8'h00, 1'b1);
        for (int i = 0; i < 16; i++) put(8'(i), 1'b1);
        check("sat_pulse", 32'(sync_err), 32'd1);
        check("sat_scnt", 32'(sync_cnt), 32'd15);
        check("sat_no_word", 32'(ival_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ival_packer.md
# ival_packer

Byte-to-word packer that builds the 32-bit `ival` word from an 8-bit valid/ready byte stream and holds it in a one-entry output register under a valid/ready handshake. It sits directly upstream of the clock-domain capture stage that registers slices of `ival` (bits 31:18, 6:4 and 2:0). It runs entirely on `sysclk`. Packing is MSB-first so the upper slice always comes from the first two bytes of a word.

## Interface
- `CNT_W`, default 16: width of the delivered-word and sync-error counters.
- `sysclk`  in  1  the only clock; all state changes on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `din`  in  8  input byte.
- `din_sof`  in  1  marks `din` as byte 0 of a word; qualified by `din_valid`.
- `din_valid`  in  1  byte present.
- `din_ready`  out  1  byte accepted when `din_valid && din_ready`.
- `ival`  out  32  packed word: byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
- `ival_valid`  out  1  `ival` holds an undelivered word.
- `ival_ready`  in  1  consumer takes the word when `ival_valid && ival_ready`.
- `sync_err`  out  1  one-cycle pulse: a partial word was discarded by `din_sof`.
- `word_cnt`  out  CNT_W  words delivered; wraps modulo 2^CNT_W.
- `sync_cnt`  out  CNT_W  sync errors; saturates at all-ones.

## Operation
- State: byte index `idx` (0..3), 24-bit assembly register `acc`, output register `ival` with flag `ival_valid`.
- FILL (idx 0..2): each accepted byte is shifted into `acc`, and `idx` increments.
- COMPLETE (idx 3): the accepted byte forms `{acc, din}`. This word loads `ival` and sets `ival_valid`, and `idx` returns to 0.
- `din_ready = (idx != 3) || !ival_valid || ival_ready`. Bytes 0–2 are always accepted, giving one byte per cycle of throughput while the consumer keeps up.
- Output handshake: when `ival_valid && ival_ready` and no new word is loading, clear `ival_valid`. If a load happens in the same cycle, `ival_valid` stays 1 and `ival` takes the new word.
- `ival` holds its value until it is replaced. It is never cleared on consume.
- `word_cnt` increments on every output handshake.
- Sync handling: an accepted byte with `din_sof=1` while `idx != 0` discards `acc` and becomes byte 0, so `idx` becomes 1. It also pulses `sync_err` for one cycle and increments `sync_cnt`. `din_sof=1` at `idx=0` is normal.
- `din_sof=0` on byte 0 is accepted without error; the block does not require sof.
- Reset values: `idx=0`, `acc=0`, `ival=32'h0`, `ival_valid=0`, `din_ready=1`, `sync_err=0`, `word_cnt=0`, `sync_cnt=0`.
- Reset asserted mid-word or with a held word: all state returns to the reset values on the next edge. The partial or held word is lost, and nothing is counted.

## Timing
- Latency: `ival`/`ival_valid` update on the edge that accepts byte 3, so they are visible the cycle after byte 3 is presented.
- `din_ready` is combinational from `ival_ready`, `ival_valid` and `idx`. All other outputs are registered.
- `sync_err` asserts for exactly the cycle after the offending byte is accepted.
- Back-to-back operation: 4 cycles per word when `din_valid` and `ival_ready` are held high.

## Configuration
- `IVAL_PARITY_EN` defined:
  - adds input `din_par` (1 bit, odd parity over `din`) and output `par_err` (1 bit, pulse);
  - a parity failure on any byte of a word marks the word bad;
  - at completion a bad word is dropped (no `ival` load, `ival_valid` unchanged), and `par_err` pulses for one cycle;
  - a `din_sof` resync clears the bad mark;
  - `par_err` resets to 0.
- `IVAL_PARITY_EN` undefined: the `din_par` and `par_err` ports do not exist, and every completed word is delivered.

## Test plan
- Reset, then bytes 12,34,56,78 (sof on the first) with `ival_ready=1` → `ival=32'h12345678` with `ival_valid=1` for 1 cycle, `word_cnt=1`.
- `ival_ready=0`, send 8 bytes → first word holds, `din_ready=0` while byte 8 is presented; raise `ival_ready` → second word is loaded the same cycle the first is consumed, `ival_valid` stays 1.
- Bytes AA,BB then sof+11,22,33,44 → `sync_err` pulse, `sync_cnt=1`, `ival=32'h11223344`.
- Reset asserted after 2 bytes, then 4 fresh bytes → `ival` is the fresh word only, all counters are 0 before delivery.
- With `IVAL_PARITY_EN`: bad parity on byte 2 → no `ival_valid`, `par_err` pulse, and the next good word is delivered normally.
- Stream 2^CNT_W+1 words → `word_cnt` wraps to 1.
